// File: rtl/cap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cap_ctrl_pkg
// Shared definitions for the debug-path capture controller:
//   - cap_state_t    : capture FSM state encodings (CAP_IDLE..CAP_DONE)
//   - CAP_DATA_WIDTH : default sample width (matches the trigger matcher)
//   - CAP_ADDR_WIDTH : default capture RAM address width
// -----------------------------------------------------------------------------
package cap_ctrl_pkg;

  localparam int CAP_DATA_WIDTH = 32;
  localparam int CAP_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    CAP_IDLE      = 3'd0,
    CAP_PREFILL   = 3'd1,
    CAP_WAIT_TRIG = 3'd2,
    CAP_POST      = 3'd3,
    CAP_DONE      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/cap_ctrl.sv
// -----------------------------------------------------------------------------
// cap_ctrl
// Capture controller downstream of the trigger matcher. Arms the matcher,
// streams pre-trigger and post-trigger samples into a circular capture RAM of
// depth 2^ADDR_WIDTH, and reports the trigger and readback start addresses.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous reset, active-HIGH (reset while rst_n = 1)
//   cap_start      one-cycle pulse, starts a capture (ignored while busy)
//   cap_abort      one-cycle pulse, cancels; beats cap_start and trigger
//   pre_depth      samples retained before the trigger
//   post_depth     samples from the trigger onward (trigger included)
//   tri_succeed    trigger pulse from the matcher
//   tri_data       sample from the matcher
//   tri_data_vld   sample valid
//   trigger_enable arms the matcher (high only in WAIT_TRIG)
//   mem_wr_en      RAM write strobe, one cycle after the sample
//   mem_wr_addr    RAM write address
//   mem_wr_data    RAM write data
//   cap_busy       high in PREFILL, WAIT_TRIG and POST
//   cap_done       level, capture complete
//   trig_addr      RAM address holding the trigger sample
//   start_addr     oldest retained sample, start of readback
// -----------------------------------------------------------------------------
module cap_ctrl
  import cap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CAP_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_start,
  input  logic                  cap_abort,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  input  logic [ADDR_WIDTH:0]   post_depth,
  input  logic                  tri_succeed,
  input  logic [DATA_WIDTH-1:0] tri_data,
  input  logic                  tri_data_vld,
  output logic                  trigger_enable,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  // Ring depth D as an (ADDR_WIDTH+1)-bit value.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  cap_state_t            state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH:0]   post_cnt;
  logic                  trig_pend;
  logic [ADDR_WIDTH-1:0] pre_r;
  logic [ADDR_WIDTH:0]   post_eff_r;

  // Effective post length from the live config inputs: at least the trigger
  // sample itself, and clamped so pre + post never exceeds the ring, which
  // keeps post samples from overwriting the retained pre-trigger window.
  logic [ADDR_WIDTH:0]   post_min;
  logic [ADDR_WIDTH+1:0] depth_sum;
  logic [ADDR_WIDTH:0]   post_eff_d;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    post_min   = (post_depth == '0) ? ONE_W : post_depth;
    depth_sum  = {2'b00, pre_depth} + {1'b0, post_min};
    post_eff_d = post_min;
    if (depth_sum > {1'b0, DEPTH_W}) begin
      post_eff_d = DEPTH_W - {1'b0, pre_depth};
    end
  end

  logic busy_st;
  logic wr_fire;

  assign busy_st = (state == CAP_PREFILL) || (state == CAP_WAIT_TRIG) ||
                   (state == CAP_POST);
  // Abort suppresses the write of the sample presented in its own cycle.
  assign wr_fire = tri_data_vld && busy_st && !cap_abort;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= CAP_IDLE;
      wr_addr        <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      trig_pend      <= 1'b0;
      pre_r          <= '0;
      post_eff_r     <= '0;
      trigger_enable <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      cap_busy       <= 1'b0;
      cap_done       <= 1'b0;
      trig_addr      <= '0;
      start_addr     <= '0;
    end else begin
      // Write stage: registered copy of the accepted sample and its address.
      mem_wr_en <= wr_fire;
      if (wr_fire) begin
        mem_wr_addr <= wr_addr;
        mem_wr_data <= tri_data;
      end

      if (cap_abort) begin
        state          <= CAP_IDLE;
        trigger_enable <= 1'b0;
        cap_busy       <= 1'b0;
        cap_done       <= 1'b0;
        trig_pend      <= 1'b0;
      end else begin
        case (state)
          CAP_IDLE, CAP_DONE: begin
            if (cap_start) begin
              pre_r      <= pre_depth;
              post_eff_r <= post_eff_d;
              wr_addr    <= '0;
              pre_cnt    <= '0;
              post_cnt   <= '0;
              trig_pend  <= 1'b0;
              cap_done   <= 1'b0;
              cap_busy   <= 1'b1;
              if (pre_depth == '0) begin
                state          <= CAP_WAIT_TRIG;
                trigger_enable <= 1'b1;
              end else begin
                state <= CAP_PREFILL;
              end
            end
          end

          CAP_PREFILL: begin
            // Triggers are not looked at here; the matcher is not armed yet.
            if (tri_data_vld) begin
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
              pre_cnt <= pre_cnt + ADDR_WIDTH'(1);
              if (pre_cnt + ADDR_WIDTH'(1) == pre_r) begin
                state          <= CAP_WAIT_TRIG;
                trigger_enable <= 1'b1;
              end
            end
          end

          CAP_WAIT_TRIG: begin
            if (tri_data_vld) begin
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
              if (tri_succeed || trig_pend) begin
                trig_pend      <= 1'b0;
                trig_addr      <= wr_addr;
                post_cnt       <= ONE_W;
                trigger_enable <= 1'b0;
                if (post_eff_r == ONE_W) begin
                  state      <= CAP_DONE;
                  cap_busy   <= 1'b0;
                  cap_done   <= 1'b1;
                  start_addr <= wr_addr - pre_r;
                end else begin
                  state <= CAP_POST;
                end
              end
            end else if (tri_succeed) begin
              // Trigger landed on an empty cycle: the next valid sample owns it.
              trig_pend <= 1'b1;
            end
          end

          CAP_POST: begin
            if (tri_data_vld) begin
              wr_addr  <= wr_addr + ADDR_WIDTH'(1);
              post_cnt <= post_cnt + ONE_W;
              if (post_cnt + ONE_W == post_eff_r) begin
                state      <= CAP_DONE;
                cap_busy   <= 1'b0;
                cap_done   <= 1'b1;
                start_addr <= trig_addr - pre_r;
              end
            end
          end

          default: begin
            state          <= CAP_IDLE;
            trigger_enable <= 1'b0;
            cap_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cap_ctrl
// Directed bench for cap_ctrl with a 16-entry ring (ADDR_WIDTH = 4). Sample
// data equals the sample index. A behavioural RAM captures the DUT's writes so
// retained contents can be compared with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cap_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cap_start = 1'b0;
  logic          cap_abort = 1'b0;
  logic [AW-1:0] pre_depth = '0;
  logic [AW:0]   post_depth = '0;
  logic          tri_succeed = 1'b0;
  logic [DW-1:0] tri_data = '0;
  logic          tri_data_vld = 1'b0;
  logic          trigger_enable;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          cap_busy;
  logic          cap_done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int n_vec = 0;
  int n_err = 0;

  cap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cap_start     (cap_start),
    .cap_abort     (cap_abort),
    .pre_depth     (pre_depth),
    .post_depth    (post_depth),
    .tri_succeed   (tri_succeed),
    .tri_data      (tri_data),
    .tri_data_vld  (tri_data_vld),
    .trigger_enable(trigger_enable),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .cap_busy      (cap_busy),
    .cap_done      (cap_done),
    .trig_addr     (trig_addr),
    .start_addr    (start_addr)
  );

  always #5 clk = ~clk;

  // Behavioural capture RAM plus a running write count.
  logic [DW-1:0] ram [16];
  int            wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_wr_addr] <= mem_wr_data;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit v, input bit t);
    tri_data     = DW'(d);
    tri_data_vld = v;
    tri_succeed  = t;
    tick();
    tri_data_vld = 1'b0;
    tri_succeed  = 1'b0;
  endtask

  task automatic start(input int pre, input int post);
    pre_depth  = AW'(pre);
    post_depth = (AW+1)'(post);
    cap_start  = 1'b1;
    tick();
    cap_start  = 1'b0;
  endtask

  int base;

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_busy", cap_busy, 0);
    check("rst_done", cap_done, 0);
    check("rst_te", trigger_enable, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_start_addr", start_addr, 0);
    rst_n = 1'b0;
    tick();

    // ---------------- test 1: pre=4 post=6, trigger on sample 9 ----------------
    base = wr_cnt;
    start(4, 6);
    check("t1_busy", cap_busy, 1);
    check("t1_te_prefill", trigger_enable, 0);
    for (int i = 0; i < 15; i++) begin
      send(i, 1'b1, i == 9);
      check("t1_wr_en", mem_wr_en, 1);
      check("t1_wr_addr", mem_wr_addr, i);
      check("t1_wr_data", mem_wr_data, i);
      if (i == 3) check("t1_te_wait", trigger_enable, 1);
      if (i == 9) check("t1_te_post", trigger_enable, 0);
      if (i == 13) check("t1_not_done", cap_done, 0);
    end
    check("t1_done", cap_done, 1);
    check("t1_busy_end", cap_busy, 0);
    check("t1_trig_addr", trig_addr, 9);
    check("t1_start_addr", start_addr, 5);
    tick();
    check("t1_no_wr_after", mem_wr_en, 0);
    check("t1_wr_count", wr_cnt - base, 15);

    // ---------------- test 2: pre=8 post=8, trigger on sample 30 ----------------
    base = wr_cnt;
    start(8, 8);
    check("t2_done_cleared", cap_done, 0);
    for (int i = 0; i < 38; i++) begin
      send(i, 1'b1, i == 30);
      if (i == 30) check("t2_trig_wr_addr", mem_wr_addr, 14);
    end
    check("t2_done", cap_done, 1);
    check("t2_trig_addr", trig_addr, 14);
    check("t2_start_addr", start_addr, 6);
    tick();
    check("t2_wr_count", wr_cnt - base, 38);
    for (int k = 0; k < 16; k++) check("t2_ram", ram[(6 + k) % 16], 22 + k);

    // ---------------- test 3: pre=12 post=10 -> post_eff=4 ----------------
    start(12, 10);
    for (int i = 0; i < 18; i++) begin
      send(i, 1'b1, i == 14);
      if (i == 16) check("t3_not_done", cap_done, 0);
    end
    check("t3_done", cap_done, 1);
    check("t3_trig_addr", trig_addr, 14);
    check("t3_start_addr", start_addr, 2);
    tick();
    for (int k = 0; k < 16; k++) check("t3_ram", ram[(2 + k) % 16], 2 + k);

    // ---------------- test 4: pending trigger, then abort mid-POST ----------------
    base = wr_cnt;
    start(4, 6);
    for (int i = 0; i < 20; i++) send(i, 1'b1, 1'b0);
    send(99, 1'b0, 1'b1);
    check("t4_no_wr_novld", mem_wr_en, 0);
    check("t4_te_pending", trigger_enable, 1);
    send(20, 1'b1, 1'b0);
    check("t4_trig_addr", trig_addr, 4);
    check("t4_te_post", trigger_enable, 0);
    send(21, 1'b1, 1'b0);
    send(22, 1'b1, 1'b0);
    cap_abort = 1'b1;
    send(23, 1'b1, 1'b0);
    cap_abort = 1'b0;
    check("t4_abort_busy", cap_busy, 0);
    check("t4_abort_wr_en", mem_wr_en, 0);
    check("t4_abort_done", cap_done, 0);
    check("t4_abort_te", trigger_enable, 0);
    send(24, 1'b1, 1'b1);
    check("t4_idle_wr_en", mem_wr_en, 0);
    send(25, 1'b1, 1'b1);
    check("t4_idle_busy", cap_busy, 0);
    tick();
    check("t4_wr_count", wr_cnt - base, 23);

    // ---------------- test 5: pre=0 post=0 ----------------
    start(0, 0);
    check("t5_busy", cap_busy, 1);
    check("t5_te_direct", trigger_enable, 1);
    send(0, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0);
    send(2, 1'b1, 1'b0);
    send(3, 1'b1, 1'b1);
    check("t5_wr_addr", mem_wr_addr, 3);
    check("t5_done", cap_done, 1);
    check("t5_trig_addr", trig_addr, 3);
    check("t5_start_addr", start_addr, 3);
    check("t5_te_off", trigger_enable, 0);

    // ---------------- test 6: start+abort, trigger in PREFILL, start while busy ----------------
    cap_abort = 1'b1;
    start(4, 2);
    cap_abort = 1'b0;
    check("t6_sa_busy", cap_busy, 0);
    check("t6_sa_done", cap_done, 0);
    start(4, 2);
    send(0, 1'b1, 1'b0);
    send(1, 1'b1, 1'b1);
    check("t6_prefill_te", trigger_enable, 0);
    check("t6_prefill_busy", cap_busy, 1);
    send(2, 1'b1, 1'b0);
    send(3, 1'b1, 1'b0);
    check("t6_wait_te", trigger_enable, 1);
    cap_start = 1'b1;
    send(4, 1'b1, 1'b0);
    cap_start = 1'b0;
    check("t6_busy_start_addr", mem_wr_addr, 4);
    check("t6_busy_start_te", trigger_enable, 1);
    send(5, 1'b1, 1'b1);
    check("t6_trig_addr", trig_addr, 5);
    send(6, 1'b1, 1'b0);
    check("t6_done", cap_done, 1);
    check("t6_start_addr", start_addr, 1);

    // ---------------- reset mid-capture ----------------
    start(2, 2);
    send(0, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0);
    check("rm_te_before", trigger_enable, 1);
    #2;
    rst_n = 1'b1;
    #1;
    check("rm_te", trigger_enable, 0);
    check("rm_busy", cap_busy, 0);
    check("rm_wr_en", mem_wr_en, 0);
    check("rm_trig_addr", trig_addr, 0);
    check("rm_start_addr", start_addr, 0);
    check("rm_done", cap_done, 0);
    tick();
    rst_n = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
